// File: rtl/spi_ctrl_master.sv
// SPI controller: turns a one-cycle read/write request into a {command, data}
// frame with programmable CPOL/CPHA and SCLK divider, returning read data and a done pulse.
module spi_ctrl_master #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic [1:0]            mode,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      rdata,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int FW = 2 * WIDTH;
  localparam int BW = $clog2(FW + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] BITS_END = BW'(FW);
  localparam logic [DW-1:0] DIV_END  = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t           state_q;
  logic [DW-1:0]    div_q;
  logic [BW-1:0]    bit_q;
  logic             lead_q;
  logic             cpha_q;
  logic             rw_q;
  logic             cs_n_q;
  logic             sclk_q;
  logic             mosi_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] rdata_q;
  logic [FW-1:0]    sh_q, sh_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] cmd_word;
  logic             accept, tick, edge_lead, edge_trail, shift_out, sample_in;

  always_comb begin
    cmd_word                   = '0;
    cmd_word[WIDTH-1]          = rw;
    cmd_word[ADDR_WIDTH-1:0]   = addr;
  end

  // A request in the done cycle is dropped: done_q is still high there.
  assign accept     = ena && (state_q == S_IDLE) && start && !done_q;
  assign tick       = ena && (div_q == DIV_END);
  assign edge_lead  = tick && ((state_q == S_SETUP) ||
                               ((state_q == S_SHIFT) && !lead_q && (bit_q != BITS_END)));
  assign edge_trail = tick && (state_q == S_SHIFT) && lead_q;
  assign shift_out  = cpha_q ? edge_lead : edge_trail;
  assign sample_in  = cpha_q ? edge_trail : edge_lead;

  always_comb begin
    sh_d = sh_q;
    rx_d = rx_q;
    if (accept) begin
      sh_d = {cmd_word, (rw ? wdata : {WIDTH{1'b0}})};
    end else if (shift_out) begin
      sh_d = {sh_q[FW-2:0], 1'b0};
    end
    if (sample_in) begin
      rx_d = {rx_q[WIDTH-2:0], spi_miso};
    end
  end

  // Shift registers carry no reset; they are fully reloaded/refilled every frame.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
    rx_q <= rx_d;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      lead_q  <= 1'b0;
      cpha_q  <= 1'b0;
      rw_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else if (ena) begin
      if (shift_out) mosi_q <= cpha_q ? sh_q[FW-1] : sh_q[FW-2];
      if (edge_lead || edge_trail) sclk_q <= ~sclk_q;
      case (state_q)
        S_IDLE: begin
          cs_n_q <= 1'b1;
          sclk_q <= mode[1];
          mosi_q <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          div_q  <= '0;
          if (accept) begin
            state_q <= S_SETUP;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cpha_q  <= mode[0];
            rw_q    <= rw;
            mosi_q  <= mode[0] ? 1'b0 : rw;
          end
        end
        S_SETUP: begin
          if (tick) begin
            div_q   <= '0;
            bit_q   <= '0;
            lead_q  <= 1'b1;
            state_q <= S_SHIFT;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_SHIFT: begin
          // Last half-period runs its full length before entering HOLD.
          if (tick) begin
            div_q <= '0;
            if (lead_q) begin
              lead_q <= 1'b0;
              bit_q  <= bit_q + 1'b1;
            end else if (bit_q == BITS_END) begin
              state_q <= S_HOLD;
              mosi_q  <= 1'b0;
            end else begin
              lead_q <= 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (tick) begin
            div_q   <= '0;
            state_q <= S_IDLE;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            if (!rw_q) rdata_q <= rx_q;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign spi_cs_n = cs_n_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_ctrl_master.sv
// Randomized bench for spi_ctrl_master with a bit-level SPI peripheral model
// and a cycle-position reference for CS, SCLK, busy, done and rdata.
module tb_spi_ctrl_master;

  localparam int W      = 8;
  localparam int AW     = 3;
  localparam int D      = 2;
  localparam int DONE_N = 1 + (4 * W + 2) * D;

  logic          clk;
  logic          rstb;
  logic          ena;
  logic [1:0]    mode;
  logic          start;
  logic          rw;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata;
  logic          busy;
  logic          done;
  logic [W-1:0]  rdata;
  logic          spi_cs_n;
  logic          spi_clk;
  logic          spi_mosi;
  logic          spi_miso;

  int            n_chk;
  int            n_bad;
  logic          p_cpha;
  logic [2*W-1:0] p_resp;
  int            p_ptr;
  int            p_edges;
  logic [2*W-1:0] mosi_cap;
  logic          cs_prev;
  logic          sclk_prev;
  logic [W-1:0]  exp_rdata;

  spi_ctrl_master #(.WIDTH(W), .ADDR_WIDTH(AW), .CLK_DIV(D)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .mode     (mode),
    .start    (start),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Number of SCLK edges a frame has produced by cycle n after acceptance.
  function automatic int exp_edges(input int n);
    int e;
    if (n < 1 + D) return 0;
    e = (n - 1) / D;
    return (e > 4 * W) ? 4 * W : e;
  endfunction

  // Standard SPI slave: presents response bits, captures MOSI on the sampling edge.
  task automatic periph_step();
    bit lead;
    bit smp;
    if (cs_prev && !spi_cs_n) begin
      p_edges  = 0;
      p_ptr    = 2 * W - 1;
      mosi_cap = '0;
      if (!p_cpha) spi_miso = p_resp[p_ptr];
    end else if (!spi_cs_n && (spi_clk != sclk_prev)) begin
      p_edges++;
      lead = (p_edges % 2) == 1;
      smp  = p_cpha ? !lead : lead;
      if (smp) begin
        mosi_cap = {mosi_cap[2*W-2:0], spi_mosi};
      end else if (p_cpha) begin
        if (p_ptr >= 0) spi_miso = p_resp[p_ptr];
        p_ptr--;
      end else begin
        p_ptr--;
        if (p_ptr >= 0) spi_miso = p_resp[p_ptr];
      end
    end
    cs_prev   = spi_cs_n;
    sclk_prev = spi_clk;
  endtask

  task automatic run_txn(input logic t_rw, input logic [AW-1:0] t_addr, input logic [W-1:0] t_wdata,
                         input logic [1:0] t_mode, input logic [2*W-1:0] t_resp, input bit pre_idle,
                         input bit start_on_done, input int stall_at, input int abort_at);
    logic [2*W-1:0] frame;
    logic [W-1:0]   want_rd;
    int             n_eff;
    int             n_abs;
    int             left;
    int             e;
    bit             stalled;
    bit             ena_prev;
    bit             fin;
    bit             done_seen;
    frame   = {t_rw, {(W-1-AW){1'b0}}, t_addr, (t_rw ? t_wdata : {W{1'b0}})};
    p_cpha  = t_mode[0];
    p_resp  = t_resp;
    want_rd = t_rw ? exp_rdata : t_resp[W-1:0];
    if (pre_idle) begin
      start = 1'b0;
      mode  = t_mode;
      ena   = 1'b1;
      @(negedge clk);
      periph_step();
      chk_val("idle_cs_n", 32'(spi_cs_n), 32'd1);
      chk_val("idle_sclk", 32'(spi_clk), 32'(t_mode[1]));
      chk_val("idle_busy", 32'(busy), 32'd0);
    end
    start = 1'b1;
    rw    = t_rw;
    addr  = t_addr;
    wdata = t_wdata;
    mode  = t_mode;
    ena   = 1'b1;
    n_eff = 0;
    n_abs = 0;
    left  = 0;
    stalled   = 1'b0;
    fin       = 1'b0;
    done_seen = 1'b0;
    while (!fin) begin
      ena_prev = ena;
      @(negedge clk);
      n_abs++;
      if (ena_prev) n_eff++;
      periph_step();
      if (abort_at != 0 && n_eff == abort_at) begin
        rstb = 1'b0;
        #1;
        chk_val("abort_cs_n", 32'(spi_cs_n), 32'd1);
        chk_val("abort_sclk", 32'(spi_clk), 32'd0);
        chk_val("abort_busy", 32'(busy), 32'd0);
        chk_val("abort_mosi", 32'(spi_mosi), 32'd0);
        start = 1'b0;
        ena   = 1'b1;
        repeat (2) begin
          @(negedge clk);
          periph_step();
          chk_val("abort_done", 32'(done), 32'd0);
          chk_val("abort_rdata", 32'(rdata), 32'd0);
        end
        rstb      = 1'b1;
        exp_rdata = '0;
        return;
      end
      chk_val("cs_n", 32'(spi_cs_n), (n_eff <= DONE_N - 1) ? 32'd0 : 32'd1);
      chk_val("busy", 32'(busy), (n_eff <= DONE_N) ? 32'd1 : 32'd0);
      chk_val("done", 32'(done), (n_eff == DONE_N) ? 32'd1 : 32'd0);
      chk_val("rdata", 32'(rdata), 32'((n_eff == DONE_N) ? want_rd : exp_rdata));
      if (n_eff <= DONE_N) begin
        e = exp_edges(n_eff);
        chk_val("sclk", 32'(spi_clk), 32'(t_mode[1] ^ ((e % 2) == 1)));
      end
      if (n_eff == 1 && !t_mode[0]) chk_val("mosi_first", 32'(spi_mosi), 32'(frame[2*W-1]));
      if (n_eff == DONE_N && !done_seen) begin
        done_seen = 1'b1;
        chk_val("done_cycle", 32'(n_abs), 32'(DONE_N + ((stall_at != 0) ? 5 : 0)));
        chk_val("mosi_frame", 32'(mosi_cap), 32'(frame));
        chk_val("edge_count", 32'(p_edges), 32'(4 * W));
        exp_rdata = want_rd;
      end
      if (n_eff == DONE_N + 1) begin
        start = 1'b0;
        fin   = 1'b1;
      end else begin
        start = (n_eff == DONE_N) ? start_on_done : 1'($urandom_range(0, 1));
        rw    = 1'($urandom);
        addr  = AW'($urandom);
        wdata = W'($urandom);
        mode  = 2'($urandom);
      end
      if (left > 0) begin
        left--;
        if (left == 0) ena = 1'b1;
      end else if (stall_at != 0 && !stalled && n_eff == stall_at) begin
        ena     = 1'b0;
        left    = 5;
        stalled = 1'b1;
      end
    end
  endtask

  initial begin
    n_chk     = 0;
    n_bad     = 0;
    rstb      = 1'b0;
    ena       = 1'b1;
    start     = 1'b0;
    rw        = 1'b0;
    addr      = '0;
    wdata     = '0;
    mode      = 2'b00;
    spi_miso  = 1'b0;
    cs_prev   = 1'b1;
    sclk_prev = 1'b0;
    p_cpha    = 1'b0;
    p_resp    = '0;
    p_ptr     = 0;
    p_edges   = 0;
    mosi_cap  = '0;
    exp_rdata = '0;
    repeat (3) @(negedge clk);
    chk_val("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk_val("rst_sclk", 32'(spi_clk), 32'd0);
    chk_val("rst_mosi", 32'(spi_mosi), 32'd0);
    chk_val("rst_busy", 32'(busy), 32'd0);
    chk_val("rst_done", 32'(done), 32'd0);
    chk_val("rst_rdata", 32'(rdata), 32'd0);
    rstb = 1'b1;

    run_txn(1'b1, 3'd3, 8'hA5, 2'b00, 16'($urandom), 1'b1, 1'b0, 0, 0);
    for (int m = 0; m < 4; m++)
      run_txn(1'b0, AW'($urandom), W'($urandom), 2'(m), {8'($urandom), 8'h3C}, 1'b1, 1'b0, 0, 0);

    run_txn(1'b0, AW'($urandom), W'($urandom), 2'($urandom), 16'($urandom), 1'b1, 1'b1, 0, 0);
    run_txn(1'b1, AW'($urandom), W'($urandom), 2'($urandom), 16'($urandom), 1'b0, 1'b1, 0, 0);
    run_txn(1'b0, AW'($urandom), W'($urandom), 2'($urandom), 16'($urandom), 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 6; i++)
      run_txn(1'($urandom), AW'($urandom), W'($urandom), 2'($urandom), 16'($urandom),
              1'($urandom), 1'($urandom), 0, 0);

    run_txn(1'b0, AW'($urandom), W'($urandom), 2'($urandom), 16'($urandom), 1'b1, 1'b0, 20, 0);

    run_txn(1'b0, AW'($urandom), W'($urandom), 2'($urandom), 16'($urandom), 1'b1, 1'b0, 0, 1 + 15 * D);
    run_txn(1'b0, AW'($urandom), W'($urandom), 2'($urandom), 16'($urandom), 1'b1, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_ctrl_master.md
# spi_ctrl_master

SPI controller that issues single-register read and write transactions to the team's SPI register-file wrapper (the peripheral side). It turns a one-cycle parallel request into a two-word SPI frame with programmable CPOL/CPHA and SCLK divider, and returns read data plus a done pulse. It sits in test/bring-up designs and host-side logic that drives the `spi_cs_n` / `spi_clk` / `spi_mosi` / `spi_miso` pins of the peripheral.

## Interface
- `WIDTH`, 8: register/word width in bits; frame = 2*WIDTH bits.
- `ADDR_WIDTH`, 3: address bits; must be <= WIDTH-1.
- `CLK_DIV`, 4: SCLK half-period in `clk` cycles; >= 1.

- `clk`  in  1  system clock.
- `rstb`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  clock enable; when low all state holds.
- `mode`  in  2  {CPOL, CPHA}; sampled only when a request is accepted.
- `start`  in  1  request strobe; accepted only in IDLE with `ena`=1.
- `rw`  in  1  1 = write, 0 = read.
- `addr`  in  ADDR_WIDTH  register address.
- `wdata`  in  WIDTH  write data.
- `busy`  out  1  high from the cycle after acceptance through the `done` cycle.
- `done`  out  1  one-cycle pulse at transaction end.
- `rdata`  out  WIDTH  last read data; updated only at end of a read.
- `spi_cs_n`  out  1  chip select, active low.
- `spi_clk`  out  1  SCLK.
- `spi_mosi`  out  1  controller-to-peripheral data.
- `spi_miso`  in  1  peripheral-to-controller data (already synchronous or externally synchronized).

## Operation
- Frame, MSB first: command word {rw, zeros, addr} (rw at bit WIDTH-1, addr in bits ADDR_WIDTH-1:0), then data word (`wdata` for writes, all zeros driven for reads).
- On acceptance: latch `mode`, `rw`, `addr`, `wdata` into a 2*WIDTH shift register; later changes on the inputs have no effect.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
  - IDLE: `spi_cs_n`=1, `spi_clk` registers live `mode[1]` each enabled cycle, `spi_mosi`=0.
  - SETUP: `spi_cs_n`=0 for CLK_DIV cycles, SCLK at CPOL; for CPHA=0 MOSI already carries bit 2*WIDTH-1.
  - SHIFT: 2*WIDTH SCLK periods, SCLK toggles every CLK_DIV cycles. CPHA=0: sample MISO on leading edge, shift MOSI on trailing edge. CPHA=1: shift MOSI on leading edge (first bit presented there), sample on trailing edge.
  - HOLD: SCLK back at CPOL, `spi_cs_n`=0 for CLK_DIV cycles; then `spi_cs_n`=1, `done`=1, return to IDLE.
- `rdata` <= the last WIDTH bits sampled (data word) at `done`, reads only; writes leave `rdata` unchanged. Command-word MISO bits are discarded.
- `start` while busy: ignored, not queued. `start` in the `done` cycle: ignored; next acceptance earliest the following cycle.
- `ena`=0: every register, counter and output holds, including mid-frame (SCLK stretches).
- Bit counter width clog2(2*WIDTH+1); divider counter width clog2(CLK_DIV+1); no wrap beyond terminal counts.

## Timing
- Reset values: `spi_cs_n`=1, `spi_clk`=0, `spi_mosi`=0, `busy`=0, `done`=0, `rdata`=0, state IDLE. Reset mid-frame aborts immediately (CS deasserts asynchronously, no `done`).
- With `start` accepted at cycle 0 (ena held 1): `spi_cs_n` falls and `busy` rises at cycle 1; first SCLK edge at cycle 1+CLK_DIV; last SCLK edge at cycle 1+(4*WIDTH+1)*CLK_DIV-CLK_DIV; `done`=1, `spi_cs_n`=1, `busy`=1 at cycle 1+(4*WIDTH+2)*CLK_DIV; `busy`=0 the cycle after.
- Outputs are registered; no combinational path from `spi_miso` or `start` to any output.

## Test plan
- Write, mode 0, CLK_DIV=2, WIDTH=8: start rw=1 addr=3 wdata=0xA5 at cycle 0 -> MOSI stream 0x83 then 0xA5 sampled on rising SCLK, cs_n low cycles 1..68, done at cycle 69, rdata unchanged (0x00).
- Read, all four modes: peripheral model returns 0x3C -> rdata=0x3C at done; MOSI data word 0x00; SCLK idles at CPOL before and after; edge counts = 32 per frame.
- Back-to-back: start pulsed again during busy and on done cycle -> ignored; start one cycle after done -> second frame starts, cs_n high for at least one cycle between frames.
- ena toggling: ena=0 for 5 cycles mid-SHIFT -> all outputs frozen, done delayed by exactly 5 cycles, data correct.
- Reset mid-frame: rstb low at bit 7 -> cs_n=1, spi_clk=0, busy=0 asynchronously, no done; a new read after reset returns correct data.
- Mode latch: change `mode`, `addr`, `wdata` during busy -> frame uses values captured at acceptance.
